// File: rtl/filt_pkg.sv
// Shared definitions for the filt FIR front end and its bit-serial transmitter.
// Bit order of the transmitter is selected by FILT_TX_LSB_FIRST_EN (see filt_tx_shifter).
package filt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    localparam int FILT_WORD_W     = 8;
    localparam int FILT_GAP_CYCLES = 2;
    localparam int FILT_CNT_W      = 16;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filt_tx_shifter.sv
// Output shift register and bit counter for filt_bit_tx.
// FILT_TX_LSB_FIRST_EN selects LSB-first (right shift); default is MSB-first.
module filt_tx_shifter
    import filt_pkg::*;
#(
    parameter int WORD_W = FILT_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic              bit_out,
    output logic              last
);

    localparam int CNT_W = cnt_width(WORD_W);

    logic [WORD_W-1:0] shifter;
    logic [CNT_W-1:0]  bitcnt;

    // Zeros are shifted in, so the register drains to 0 and BitOut idles low
    // without extra gating once the last bit has gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= '0;
            bitcnt  <= '0;
        end else if (load) begin
            shifter <= data;
            bitcnt  <= CNT_W'(WORD_W - 1);
        end else begin
`ifdef FILT_TX_LSB_FIRST_EN
            shifter <= {1'b0, shifter[WORD_W-1:1]};
`else
            shifter <= {shifter[WORD_W-2:0], 1'b0};
`endif
            if (bitcnt != '0) begin
                bitcnt <= bitcnt - CNT_W'(1);
            end
        end
    end

`ifdef FILT_TX_LSB_FIRST_EN
    assign bit_out = shifter[0];
`else
    assign bit_out = shifter[WORD_W-1];
`endif

    assign last = (bitcnt == '0);

endmodule

// File: rtl/filt_bit_tx.sv
// Bit-serial word transmitter driving filt's BitIn/FILTER pins.
// Bit order follows FILT_TX_LSB_FIRST_EN (handled in filt_tx_shifter).
module filt_bit_tx
    import filt_pkg::*;
#(
    parameter int WORD_W     = FILT_WORD_W,
    parameter int GAP_CYCLES = FILT_GAP_CYCLES
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  BitOut,
    output logic                  FILTER,
    output logic                  busy,
    output logic [FILT_CNT_W-1:0] words_sent
);

    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    tx_state_e         state;
    tx_state_e         state_next;
    logic [WORD_W-1:0] pending;
    logic              pending_full;
    logic [GAP_W-1:0]  gapcnt;
    logic              accept;
    logic              load;
    logic              last;

    // valid/ready: a word transfers on a rising edge where in_valid && in_ready;
    // in_data is only sampled then, and in_ready never depends on in_valid.
    assign in_ready = Reset && !pending_full;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending_full) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (GAP_CYCLES > 0) begin
                    state_next = ST_GAP;
                end else if (pending_full) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gapcnt == '0) begin
                    if (pending_full) begin
                        load       = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FILTER, busy and words_sent are registered from the next state so they
    // line up with the state they describe.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            pending_full <= 1'b0;
            gapcnt       <= '0;
            FILTER       <= 1'b0;
            busy         <= 1'b0;
            words_sent   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pending      <= in_data;
                pending_full <= 1'b1;
            end else if (load) begin
                pending_full <= 1'b0;
            end
            if (state == ST_PULSE) begin
                gapcnt <= GAP_LOAD;
            end else if (state == ST_GAP && gapcnt != '0) begin
                gapcnt <= gapcnt - GAP_W'(1);
            end
            FILTER <= (state_next == ST_PULSE);
            busy   <= (state_next != ST_IDLE);
            if (state_next == ST_PULSE) begin
                words_sent <= words_sent + FILT_CNT_W'(1);
            end
        end
    end

    filt_tx_shifter #(
        .WORD_W(WORD_W)
    ) u_shifter (
        .clk    (Clock),
        .rst_n  (Reset),
        .load   (load),
        .data   (pending),
        .bit_out(BitOut),
        .last   (last)
    );

endmodule

// File: doc/filt_bit_tx.md
# filt_bit_tx

Bit-serial word transmitter feeding the `filt` FIR front end. It accepts parallel sample words over a valid/ready handshake and shifts each word out on `BitOut`, one bit per clock. It then pulses `FILTER` for one cycle so `filt` transfers its input shift buffer to its compute buffer. It sits between the sample source and `filt`, and drives `filt`'s `BitIn`/`FILTER` pins directly.

## Interface
Parameters:
- `WORD_W`, 8: bits per word; equals the `filt` input buffer length.
- `GAP_CYCLES`, 2: minimum idle cycles after the `FILTER` pulse before the next word's first bit (filter compute time); 0 allowed.

Ports:
- `Clock`  in  1  single clock domain.
- `Reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  WORD_W  parallel word to transmit.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  holding register empty; the word is accepted when `in_valid && in_ready` at a rising edge.
- `BitOut`  out  1  serial bit; connects to `filt.BitIn`.
- `FILTER`  out  1  one-cycle transfer strobe; connects to `filt.FILTER`.
- `busy`  out  1  high in SHIFT, PULSE or GAP.
- `words_sent`  out  16  count of completed words (FILTER pulses), wraps at 2^16.

## Operation
- Two word stores: `pending` (holding register plus full flag) and `shifter`.
- A handshake writes `pending`, which is then full. `in_ready = !pending_full`, gated low while `Reset` is asserted.
- FSM states: IDLE, SHIFT, PULSE, GAP.
- IDLE: `BitOut=0`, `FILTER=0`. If `pending` is full, load `shifter` from it, clear `pending_full`, set `bitcnt = WORD_W-1` and go to SHIFT.
- SHIFT: `BitOut` is the current bit; `shifter` shifts each cycle. When `bitcnt==0`, go to PULSE.
- PULSE: `FILTER=1`, `BitOut=0`, `words_sent++`.
  - If `GAP_CYCLES>0`, load `gapcnt = GAP_CYCLES-1` and go to GAP.
  - Otherwise, if `pending` is full, load `shifter` and go to SHIFT; else go to IDLE.
- GAP: `BitOut=0`. When `gapcnt==0`, take the same exit as PULSE with `GAP_CYCLES=0`; otherwise decrement `gapcnt`.
- Bit order: MSB first by default, so a left-shifting receiver holds `buffer[WORD_W-1:0] == in_data` at `FILTER`.
- Same-edge load of `shifter` and new accept into `pending` is impossible: `in_ready` is 0 in the load cycle and rises the cycle after.
- `in_valid` with `in_ready=0` is ignored; `in_data` is not sampled.
- Reset mid-operation aborts the word. No `FILTER` is issued and `pending` is discarded.

## Timing
- Reset values: `in_ready=0` while `Reset` is low; 1 from the first cycle after deassertion. `BitOut=0`, `FILTER=0`, `busy=0`, `words_sent=0`, state IDLE.
- All outputs are registered except `in_ready`, which is decoded from the `pending_full` flop.
- Handshake in cycle N, from IDLE:
  - Cycle N+1: load.
  - Cycles N+2 … N+1+WORD_W: bits MSB…LSB on `BitOut`.
  - Cycle N+2+WORD_W: `FILTER=1`.
- Back-to-back words with `pending` pre-filled: one word per `WORD_W+1+GAP_CYCLES` cycles, with no IDLE bubble.
- A second word can be accepted from the cycle after the first is loaded into `shifter`.

## Configuration
- `FILT_TX_LSB_FIRST_EN`:
  - Defined: `shifter` shifts right and `BitOut` carries LSB first. Use this with a right-shifting `filt` build.
  - Undefined: MSB first.
- Handshake, counts and timing are identical in both builds.

## Structure
- `filt_pkg`: FSM state enum typedef, default `WORD_W`/`GAP_CYCLES` localparams, `words_sent` width constant. This package is shared with `filt`.
- One sub-module, `filt_tx_shifter`, holds the `shifter` register and `bitcnt`. Its ports are load, data, bit out, and last-bit flag; the bit-order macro is handled inside it.
- The FSM, `pending`, gap counter and `words_sent` live in the top module.

## Test plan
All scenarios use `WORD_W=8`, `GAP_CYCLES=2` unless stated.
- Reset release, then word 8'hA5 handshaken in cycle N → `BitOut` = 1,0,1,0,0,1,0,1 in N+2…N+9; `FILTER=1` only in N+10; `words_sent=1`.
- Back-to-back: 8'hFF then 8'h00 with `in_valid` held high → second word's first bit is 11 cycles after the first word's first bit; `in_ready` is low while `pending` is full.
- `GAP_CYCLES=0`, three queued words (8'h01, 8'h80, 8'h3C) → three `FILTER` pulses exactly 9 cycles apart; a loopback `filt` buffer equals each word at its pulse.
- Reset asserted at bit 4 of 8'hC3 → outputs 0 immediately; no `FILTER`; `words_sent=0`; the next word transmits cleanly after release.
- `in_valid` pulsed with 8'h5A while `in_ready=0` → the word is not captured; only the earlier words are transmitted.
- `FILT_TX_LSB_FIRST_EN` defined, word 8'h01 → `BitOut`=1 then seven 0s; `FILTER` timing unchanged.
